// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: pipelined IEEE-754 multiplier with valid/ready handshakes.
// Operand register, then unpack, multiply, and normalise/round/pack stages.
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter bit FTZ   = 1'b0,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic [1:0]             rnd_mode,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   p,
  output logic [TAG_W-1:0]       out_tag,
  output logic [3:0]             flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int SW   = MAN_W + 1;
  localparam int PW   = 2 * SW;
  localparam int XW   = EXP_W + 3;
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int EMAX = 2**EXP_W - 1;

  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             v;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [1:0]       rm;
    logic [TAG_W-1:0] tag;
  } s0_t;

  typedef struct packed {
    logic             v;
    logic             sign;
    logic             sp;
    logic [1:0]       rm;
    logic [TAG_W-1:0] tag;
    logic [XW-1:0]    ea;
    logic [XW-1:0]    eb;
    logic [SW-1:0]    sa;
    logic [SW-1:0]    sb;
    logic [W-1:0]     spw;
    logic [3:0]       spf;
  } s1_t;

  typedef struct packed {
    logic             v;
    logic             sign;
    logic             sp;
    logic [1:0]       rm;
    logic [TAG_W-1:0] tag;
    logic [XW-1:0]    e;
    logic [PW-1:0]    prod;
    logic [W-1:0]     spw;
    logic [3:0]       spf;
  } s2_t;

  typedef struct packed {
    logic          sign;
    logic          zero;
    logic          inf;
    logic          nan;
    logic          snan;
    logic [SW-1:0] sig;
    logic [XW-1:0] exp;
  } opnd_t;

  function automatic logic [XW-1:0] lzc(input logic [SW-1:0] v);
    lzc = XW'(SW);
    for (int i = 0; i < SW; i++)
      if (v[i]) lzc = XW'(SW - 1 - i);
  endfunction

  // Subnormals are normalised here so S2/S3 only ever see a leading one.
  function automatic opnd_t unpack(input logic [W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    logic [XW-1:0]    lz;
    e = x[W-2 -: EXP_W];
    f = x[MAN_W-1:0];
    lz = lzc({1'b0, f});
    unpack = '0;
    unpack.sign = x[W-1];
    unpack.nan  = (&e) && (|f);
    unpack.snan = (&e) && (|f) && !f[MAN_W-1];
    unpack.inf  = (&e) && !(|f);
    if (e == '0) begin
      unpack.zero = !(|f) || FTZ;
      unpack.sig  = {1'b0, f} << lz;
      unpack.exp  = XW'(1) - lz;
    end else begin
      unpack.sig = {1'b1, f};
      unpack.exp = XW'(e);
    end
  endfunction

  s0_t r0, n0;
  s1_t r1, n1;
  s2_t r2, n2;
  opnd_t ua, ub;
  logic adv;

  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  always_comb begin
    n0     = '0;
    n0.v   = in_valid;
    n0.a   = a;
    n0.b   = b;
    n0.rm  = rnd_mode;
    n0.tag = in_tag;
  end

  always_comb begin
    ua      = unpack(r0.a);
    ub      = unpack(r0.b);
    n1      = '0;
    n1.v    = r0.v;
    n1.rm   = r0.rm;
    n1.tag  = r0.tag;
    n1.sign = ua.sign ^ ub.sign;
    n1.ea   = ua.exp;
    n1.eb   = ub.exp;
    n1.sa   = ua.sig;
    n1.sb   = ub.sig;
    if (ua.nan || ub.nan) begin
      n1.sp  = 1'b1;
      n1.spw = QNAN;
      n1.spf = {ua.snan || ub.snan, 3'b000};
    end else if ((ua.inf && ub.zero) || (ua.zero && ub.inf)) begin
      n1.sp  = 1'b1;
      n1.spw = QNAN;
      n1.spf = 4'b1000;
    end else if (ua.inf || ub.inf) begin
      n1.sp  = 1'b1;
      n1.spw = {n1.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (ua.zero || ub.zero) begin
      n1.sp  = 1'b1;
      n1.spw = {n1.sign, {(W-1){1'b0}}};
    end
  end

  always_comb begin
    n2      = '0;
    n2.v    = r1.v;
    n2.sign = r1.sign;
    n2.sp   = r1.sp;
    n2.rm   = r1.rm;
    n2.tag  = r1.tag;
    n2.spw  = r1.spw;
    n2.spf  = r1.spf;
    n2.e    = r1.ea + r1.eb - XW'(BIAS);
    n2.prod = PW'(r1.sa) * PW'(r1.sb);
  end

  logic [PW-1:0]    m, ms, mask;
  logic [XW-1:0]    e, sh, ef;
  logic [SW-1:0]    k;
  logic [SW:0]      kr;
  logic [MAN_W-1:0] frac;
  logic             tiny, g, s, inc, inx, ovf, to_inf;
  logic [W-1:0]     res;
  logic [3:0]       fl;

  always_comb begin
    m    = r2.prod[PW-1] ? r2.prod : r2.prod << 1;
    e    = r2.e + XW'(r2.prod[PW-1]);
    tiny = e[XW-1] || (e == '0);
    sh   = tiny ? XW'(1) - e : '0;
    if (sh > XW'(PW)) sh = XW'(PW);
    // Bits shifted out for the subnormal range collapse into the sticky LSB.
    mask = ~({PW{1'b1}} << sh);
    ms   = (m >> sh) | PW'(|(m & mask));
    k    = ms[PW-1 -: SW];
    g    = ms[PW-1-SW];
    s    = |ms[PW-2-SW:0];
    inx  = g || s;
    unique case (r2.rm)
      2'd0: inc = g && (s || k[0]);
      2'd1: inc = 1'b0;
      2'd2: inc = !r2.sign && inx;
      2'd3: inc = r2.sign && inx;
    endcase
    kr     = {1'b0, k} + {{SW{1'b0}}, inc};
    ef     = tiny ? XW'(kr[SW-1]) : e + XW'(kr[SW]);
    frac   = kr[SW] ? '0 : kr[MAN_W-1:0];
    ovf    = !tiny && (ef >= XW'(EMAX));
    to_inf = (r2.rm == 2'd0) ||
             (r2.rm == 2'd2 && !r2.sign) ||
             (r2.rm == 2'd3 && r2.sign);
    res = {r2.sign, ef[EXP_W-1:0], frac};
    fl  = {2'b00, tiny && inx, inx};
    if (r2.sp) begin
      res = r2.spw;
      fl  = r2.spf;
    end else if (ovf) begin
      res = to_inf ?
        {r2.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
        {r2.sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      fl  = 4'b0101;
    end else if (tiny && FTZ) begin
      res = {r2.sign, {(W-1){1'b0}}};
      fl  = 4'b0011;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0        <= '0;
      r1        <= '0;
      r2        <= '0;
      out_valid <= 1'b0;
      p         <= '0;
      out_tag   <= '0;
      flags     <= '0;
    end else if (adv) begin
      r0        <= n0;
      r1        <= n1;
      r2        <= n2;
      out_valid <= r2.v;
      p         <= res;
      out_tag   <= r2.tag;
      flags     <= fl;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: directed FP32 vectors, stall stream and reset-in-flight
// sequences for fp_mult_pipe, plus an FTZ=1 instance on the same inputs.
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready, in_ready_f;
  logic [31:0] a, b;
  logic [1:0]  rnd_mode;
  logic [3:0]  in_tag;
  logic        out_valid, out_valid_f;
  logic        out_ready;
  logic [31:0] p, p_f;
  logic [3:0]  out_tag, out_tag_f;
  logic [3:0]  flags, flags_f;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_mult_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rnd_mode(rnd_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .out_tag(out_tag), .flags(flags)
  );

  fp_mult_pipe #(.FTZ(1'b1)) dut_f (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_f),
    .a(a), .b(b), .rnd_mode(rnd_mode), .in_tag(in_tag),
    .out_valid(out_valid_f), .out_ready(out_ready),
    .p(p_f), .out_tag(out_tag_f), .flags(flags_f)
  );

  typedef struct {
    logic [1:0]  rm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    logic [3:0]  fl;
  } vec_t;

  localparam int NV = 26;
  vec_t vt [NV];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Launch one op with an idle pipe and wait for its result.
  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb,
                        input logic [1:0] rm, input logic [3:0] tg,
                        output int lat);
    @(negedge clk);
    a = xa; b = xb; rnd_mode = rm; in_tag = tg; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 10);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, sent, got, emitted, wait_c;
    logic acc, hold_prev;
    logic [31:0] hp;
    logic [3:0] ht;

    vt[0]  = '{2'd0, 32'h40400000, 32'h40000000, 32'h40C00000, 4'h0};
    vt[1]  = '{2'd0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'h8};
    vt[2]  = '{2'd0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'h8};
    vt[3]  = '{2'd0, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'h0};
    vt[4]  = '{2'd0, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'h5};
    vt[5]  = '{2'd1, 32'h7F7FFFFF, 32'h40000000, 32'h7F7FFFFF, 4'h5};
    vt[6]  = '{2'd3, 32'h7F7FFFFF, 32'h40000000, 32'h7F7FFFFF, 4'h5};
    vt[7]  = '{2'd2, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'h5};
    vt[8]  = '{2'd3, 32'hFF7FFFFF, 32'h40000000, 32'hFF800000, 4'h5};
    vt[9]  = '{2'd2, 32'hFF7FFFFF, 32'h40000000, 32'hFF7FFFFF, 4'h5};
    vt[10] = '{2'd0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'h1};
    vt[11] = '{2'd2, 32'h3F800001, 32'h3F800001, 32'h3F800003, 4'h1};
    vt[12] = '{2'd0, 32'h3FB504F3, 32'h3FB504F3, 32'h3FFFFFFF, 4'h1};
    vt[13] = '{2'd2, 32'h3FB504F3, 32'h3FB504F3, 32'h40000000, 4'h1};
    vt[14] = '{2'd0, 32'h00800000, 32'h3F000000, 32'h00400000, 4'h0};
    vt[15] = '{2'd0, 32'h00000001, 32'h3F000000, 32'h00000000, 4'h3};
    vt[16] = '{2'd2, 32'h00000001, 32'h3F000000, 32'h00000001, 4'h3};
    vt[17] = '{2'd0, 32'h00000003, 32'h40000000, 32'h00000006, 4'h0};
    vt[18] = '{2'd0, 32'h007FFFFF, 32'h3F800001, 32'h00800000, 4'h3};
    vt[19] = '{2'd1, 32'h007FFFFF, 32'h3F800001, 32'h007FFFFF, 4'h3};
    vt[20] = '{2'd0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'h0};
    vt[21] = '{2'd0, 32'h80000000, 32'h40000000, 32'h80000000, 4'h0};
    vt[22] = '{2'd0, 32'hC0000000, 32'h3FC00000, 32'hC0400000, 4'h0};
    vt[23] = '{2'd0, 32'h7F800000, 32'hFF800000, 32'hFF800000, 4'h0};
    vt[24] = '{2'd3, 32'h00000001, 32'hBF000000, 32'h80000001, 4'h3};
    vt[25] = '{2'd1, 32'h3FB504F3, 32'hBFB504F3, 32'hBFFFFFFF, 4'h1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; rnd_mode = '0; in_tag = '0;
    #3;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_p", p, 32'd0);
    check("reset_flags", {28'd0, flags}, 32'd0);
    check("reset_tag", {28'd0, out_tag}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].rm, 4'(i), lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
      check($sformatf("v%0d_p", i), p, vt[i].p);
      check($sformatf("v%0d_flags", i), {28'd0, flags}, {28'd0, vt[i].fl});
      check($sformatf("v%0d_tag", i), {28'd0, out_tag}, 32'(i % 16));
    end

    run_op(32'h00800000, 32'h3F000000, 2'd0, 4'd1, lat);
    check("ftz_tiny_valid", {31'd0, out_valid_f}, 32'd1);
    check("ftz_tiny_p", p_f, 32'h00000000);
    check("ftz_tiny_flags", {28'd0, flags_f}, 32'h3);
    check("ftz_ready", {31'd0, in_ready_f}, 32'd1);
    run_op(32'h00000003, 32'h40000000, 2'd0, 4'd2, lat);
    check("ftz_subin_p", p_f, 32'h00000000);
    check("ftz_subin_flags", {28'd0, flags_f}, 32'h0);
    run_op(32'h40400000, 32'h40000000, 2'd0, 4'd3, lat);
    check("ftz_normal_p", p_f, 32'h40C00000);
    check("ftz_normal_tag", {28'd0, out_tag_f}, 32'h3);

    sent = 0; got = 0; hold_prev = 1'b0; hp = '0; ht = '0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 60 && got < 6; c++) begin
      out_ready = !(c >= 3 && c < 8);
      in_valid  = (sent < 6);
      a         = 32'h3F800000 | (32'(sent) << 12);
      b         = 32'h40000000;
      rnd_mode  = 2'd0;
      in_tag    = 4'(sent + 9);
      @(negedge clk);
      if (out_valid && !out_ready)
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      if (hold_prev) begin
        check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
        check("stall_hold_p", p, hp);
        check("stall_hold_tag", {28'd0, out_tag}, {28'd0, ht});
      end
      hold_prev = out_valid && !out_ready;
      hp = p; ht = out_tag;
      if (out_valid && out_ready) begin
        check($sformatf("stream%0d_p", got), p,
              (32'h3F800000 | (32'(got) << 12)) + 32'h00800000);
        check($sformatf("stream%0d_tag", got), {28'd0, out_tag},
              32'(got + 9));
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    check("stream_sent", 32'(sent), 32'd6);
    check("stream_got", 32'(got), 32'd6);
    in_valid = 1'b0; out_ready = 1'b1;
    emitted = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) emitted++;
    end
    check("stream_no_dup", 32'(emitted), 32'd0);

    @(posedge clk);
    #1;
    out_ready = 1'b0; in_valid = 1'b1;
    a = 32'h7F7FFFFF; b = 32'h40000000; rnd_mode = 2'd0; in_tag = 4'd1;
    @(posedge clk);
    #1;
    a = 32'h40400000; in_tag = 4'd2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_c = 0;
    while (!out_valid && wait_c < 10) begin
      @(posedge clk);
      #1 wait_c++;
    end
    check("inflight_valid", {31'd0, out_valid}, 32'd1);
    check("inflight_p", p, 32'h7F800000);
    check("inflight_flags", {28'd0, flags}, 32'h5);
    check("inflight_tag", {28'd0, out_tag}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", {31'd0, out_valid}, 32'd0);
    check("rst_async_p", p, 32'd0);
    check("rst_async_flags", {28'd0, flags}, 32'd0);
    check("rst_async_tag", {28'd0, out_tag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    emitted = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) emitted++;
    end
    check("rst_nothing_emitted", 32'(emitted), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
